// File: rtl/byte_ram_rr_scheduler.sv
// Round-robin scheduler sharing one byte-enabled simple dual-port RAM among N requesters.
// Write and read ports arbitrate independently; read responses forward same-cycle writes.
module byte_ram_rr_scheduler #(
  parameter  int N  = 2,
  parameter  int AW = 6,
  parameter  int DW = 32,
  localparam int BL = DW / 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    wr_valid,
  output logic [N-1:0]    wr_ready,
  input  logic [N*AW-1:0] wr_addr,
  input  logic [N*BL-1:0] wr_be,
  input  logic [N*DW-1:0] wr_data,
  input  logic [N-1:0]    rd_valid,
  output logic [N-1:0]    rd_ready,
  input  logic [N*AW-1:0] rd_addr,
  output logic [N-1:0]    rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            ram_we,
  output logic [AW-1:0]   ram_waddr,
  output logic [BL-1:0]   ram_be,
  output logic [DW-1:0]   ram_wdata,
  output logic [AW-1:0]   ram_raddr,
  input  logic [DW-1:0]   ram_q
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  // Returns {found, index} of the first requester at or after ptr, wrapping modulo N.
  function automatic logic [PW:0] rr_pick(input logic [N-1:0] req, input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int          j;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) res = {1'b1, PW'(j)};
    end
    return res;
  endfunction

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   wr_pick, rd_pick;
  logic          wr_any, rd_any;
  logic [PW-1:0] wr_idx, rd_idx;
  logic          rsp_vld_q, rsp_vld_d;
  logic [PW-1:0] rsp_id_q, rsp_id_d;
  logic          hit_q, hit_d;
  logic [BL-1:0] be_q;
  logic [DW-1:0] wdata_q;

  always_comb begin
    wr_pick = rr_pick(wr_valid, wr_ptr_q);
    rd_pick = rr_pick(rd_valid, rd_ptr_q);
    wr_any  = wr_pick[PW] & ~reset;
    rd_any  = rd_pick[PW] & ~reset;
    wr_idx  = wr_pick[PW-1:0];
    rd_idx  = rd_pick[PW-1:0];
  end

  always_comb begin
    wr_ready  = '0;
    ram_we    = wr_any;
    ram_waddr = '0;
    ram_be    = '0;
    ram_wdata = '0;
    wr_ptr_d  = wr_ptr_q;
    if (wr_any) begin
      wr_ready[wr_idx] = 1'b1;
      ram_waddr = wr_addr[int'(wr_idx)*AW +: AW];
      ram_be    = wr_be[int'(wr_idx)*BL +: BL];
      ram_wdata = wr_data[int'(wr_idx)*DW +: DW];
      wr_ptr_d  = (wr_idx == PW'(N - 1)) ? '0 : wr_idx + 1'b1;
    end
  end

  always_comb begin
    rd_ready  = '0;
    ram_raddr = '0;
    rd_ptr_d  = rd_ptr_q;
    if (rd_any) begin
      rd_ready[rd_idx] = 1'b1;
      ram_raddr = rd_addr[int'(rd_idx)*AW +: AW];
      rd_ptr_d  = (rd_idx == PW'(N - 1)) ? '0 : rd_idx + 1'b1;
    end
    rsp_vld_d = rd_any;
    rsp_id_d  = rd_idx;
    // The RAM returns pre-write data on a same-address collision, so remember the write.
    hit_d     = wr_any & rd_any & (ram_waddr == ram_raddr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      hit_q     <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
      hit_q     <= hit_d;
      be_q      <= ram_be;
      wdata_q   <= ram_wdata;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (rsp_vld_q) rsp_valid[rsp_id_q] = 1'b1;
    rsp_data = ram_q;
    for (int b = 0; b < BL; b++) begin
      if (hit_q && be_q[b]) rsp_data[b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_byte_ram_rr_scheduler.sv
// Self-checking bench for byte_ram_rr_scheduler: directed scenarios plus randomized traffic
// compared against a behavioural memory/arbitration model.
module tb_byte_ram_rr_scheduler;
  localparam int N  = 2;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int BL = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    wr_valid, rd_valid;
  logic [N*AW-1:0] wr_addr, rd_addr;
  logic [N*BL-1:0] wr_be;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    wr_ready, rd_ready, rsp_valid;
  logic [DW-1:0]   rsp_data, ram_wdata, ram_q;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr, ram_raddr;
  logic [BL-1:0]   ram_be;

  byte_ram_rr_scheduler #(.N(N), .AW(AW), .DW(DW)) u_dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_q(ram_q)
  );

  // Second instance with four requesters for the pointer-position scenario.
  logic [3:0]      rd_valid4, wr_ready4, rd_ready4, rsp_valid4;
  logic [4*AW-1:0] rd_addr4;
  logic [DW-1:0]   rsp_data4, ram_wdata4;
  logic            ram_we4;
  logic [AW-1:0]   ram_waddr4, ram_raddr4;
  logic [BL-1:0]   ram_be4;

  byte_ram_rr_scheduler #(.N(4), .AW(AW), .DW(DW)) u_dut4 (
    .clk(clk), .reset(reset),
    .wr_valid(4'b0), .wr_ready(wr_ready4), .wr_addr({4*AW{1'b0}}), .wr_be({4*BL{1'b0}}),
    .wr_data({4*DW{1'b0}}),
    .rd_valid(rd_valid4), .rd_ready(rd_ready4), .rd_addr(rd_addr4),
    .rsp_valid(rsp_valid4), .rsp_data(rsp_data4),
    .ram_we(ram_we4), .ram_waddr(ram_waddr4), .ram_be(ram_be4), .ram_wdata(ram_wdata4),
    .ram_raddr(ram_raddr4), .ram_q(32'h0)
  );

  // RAM macro model: registered read returning pre-write data on collision.
  logic [DW-1:0] ram_mem [DEPTH];
  logic          mem_clr;
  always @(posedge clk) begin
    logic [DW-1:0] w;
    if (mem_clr) begin
      for (int a = 0; a < DEPTH; a++) ram_mem[a] <= '0;
      ram_q <= '0;
    end else begin
      ram_q <= ram_mem[ram_raddr];
      if (ram_we) begin
        w = ram_mem[ram_waddr];
        for (int b = 0; b < BL; b++) if (ram_be[b]) w[b*8 +: 8] = ram_wdata[b*8 +: 8];
        ram_mem[ram_waddr] <= w;
      end
    end
  end

  // Reference model state
  int            wptr, rptr;
  logic [DW-1:0] ref_mem [DEPTH];
  logic          exp_rsp_vld;
  int            exp_rsp_id;
  logic [DW-1:0] exp_rsp_data;
  logic [N-1:0]  exp_wr, exp_rd;
  int            exp_wi, exp_ri;
  int            n_checks, n_fail;

  task automatic model_grants();
    int i;
    exp_wr = '0; exp_rd = '0; exp_wi = -1; exp_ri = -1;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        i = (wptr + k) % N;
        if (exp_wi < 0 && wr_valid[i]) begin exp_wi = i; exp_wr[i] = 1'b1; end
        i = (rptr + k) % N;
        if (exp_ri < 0 && rd_valid[i]) begin exp_ri = i; exp_rd[i] = 1'b1; end
      end
    end
  endtask

  // Commit one cycle in the model (write first, so a same-cycle read sees new bytes), then clock.
  task automatic tick();
    model_grants();
    if (reset) begin
      wptr = 0; rptr = 0; exp_rsp_vld = 1'b0;
    end else begin
      if (exp_wi >= 0) begin
        for (int b = 0; b < BL; b++)
          if (wr_be[exp_wi*BL + b])
            ref_mem[wr_addr[exp_wi*AW +: AW]][b*8 +: 8] = wr_data[exp_wi*DW + b*8 +: 8];
        wptr = (exp_wi + 1) % N;
      end
      exp_rsp_vld = (exp_ri >= 0);
      if (exp_ri >= 0) begin
        exp_rsp_id   = exp_ri;
        exp_rsp_data = ref_mem[rd_addr[exp_ri*AW +: AW]];
        rptr = (exp_ri + 1) % N;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_valid = '0; rd_valid = '0; wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
  endtask

  task automatic set_wr(input int i, input int a, input logic [BL-1:0] be, input logic [DW-1:0] d);
    wr_valid[i] = 1'b1;
    wr_addr[i*AW +: AW] = AW'(a);
    wr_be[i*BL +: BL] = be;
    wr_data[i*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input int a);
    rd_valid[i] = 1'b1;
    rd_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; wr_valid = '1; rd_valid = '1; #1;
    n_checks++; if (wr_ready !== '0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 00", wr_ready); end
    n_checks++; if (rd_ready !== '0) begin n_fail++; $display("FAIL reset_rd_ready: got %b want 00", rd_ready); end
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    n_checks++; if (ram_raddr !== '0) begin n_fail++; $display("FAIL reset_ram_raddr: got %0d want 0", ram_raddr); end
    tick(); #1;
    n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    reset = 1'b0; idle(); set_rd(0, 1); tick();
    reset = 1'b1; idle(); tick(); #1;
    n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_drops_rsp: got %b want 00", rsp_valid); end
    reset = 1'b0; wr_valid = '1; rd_valid = '1; #1;
    n_checks++; if (wr_ready !== 2'b01) begin n_fail++; $display("FAIL post_reset_wr_grant: got %b want 01", wr_ready); end
    n_checks++; if (rd_ready !== 2'b01) begin n_fail++; $display("FAIL post_reset_rd_grant: got %b want 01", rd_ready); end
    tick(); idle();
  endtask

  task automatic test_basic();
    idle(); set_wr(0, 5, 4'b1111, 32'hDEADBEEF); tick();
    idle(); set_rd(1, 5); tick();
    idle(); #1;
    n_checks++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL basic_rsp_valid: got %b want 10", rsp_valid); end
    n_checks++; if (rsp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rsp_data: got %h want deadbeef", rsp_data); end
    tick();
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL basic_rsp_idle: got %b want 00", rsp_valid); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] e;
    idle(); reset = 1'b1; tick(); reset = 1'b0;
    wr_valid = '1; rd_valid = '1;
    for (int c = 0; c < 6; c++) begin
      #1;
      e = (c % 2 == 1) ? 2'b10 : 2'b01;
      n_checks++; if (wr_ready !== e) begin n_fail++; $display("FAIL fair_wr cycle %0d: got %b want %b", c, wr_ready, e); end
      n_checks++; if (rd_ready !== e) begin n_fail++; $display("FAIL fair_rd cycle %0d: got %b want %b", c, rd_ready, e); end
      tick();
    end
    idle();
  endtask

  task automatic test_hazard();
    idle(); set_wr(0, 9, 4'b1111, 32'h11223344); tick();
    idle(); set_wr(0, 9, 4'b0101, 32'hAABBCCDD); set_rd(1, 9); tick();
    idle(); #1;
    n_checks++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL hazard_rsp_valid: got %b want 10", rsp_valid); end
    n_checks++; if (rsp_data !== 32'h11BB33DD) begin n_fail++; $display("FAIL hazard_fwd_data: got %h want 11bb33dd", rsp_data); end
    set_rd(1, 9); tick();
    idle(); #1;
    n_checks++; if (rsp_data !== 32'h11BB33DD) begin n_fail++; $display("FAIL hazard_ram_data: got %h want 11bb33dd", rsp_data); end
    tick();
  endtask

  task automatic test_zero_be();
    idle(); set_wr(0, 3, 4'b1111, 32'h12345678); tick();
    idle(); set_wr(1, 3, 4'b0000, 32'hFFFFFFFF); #1;
    n_checks++; if (wr_ready !== 2'b10) begin n_fail++; $display("FAIL zero_be_grant: got %b want 10", wr_ready); end
    n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL zero_be_ram_we: got %b want 1", ram_we); end
    tick();
    idle(); set_rd(0, 3); tick();
    idle(); #1;
    n_checks++; if (rsp_data !== 32'h12345678) begin n_fail++; $display("FAIL zero_be_readback: got %h want 12345678", rsp_data); end
    n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL zero_be_rsp_valid: got %b want 01", rsp_valid); end
    tick();
  endtask

  task automatic test_ptr4();
    logic [3:0] seq [3];
    seq[0] = 4'b1000; seq[1] = 4'b0010; seq[2] = 4'b1000;
    idle(); rd_valid4 = '0; rd_addr4 = '0; reset = 1'b1; tick(); reset = 1'b0;
    rd_valid4 = 4'b0010; #1;
    n_checks++; if (rd_ready4 !== 4'b0010) begin n_fail++; $display("FAIL ptr4_setup: got %b want 0010", rd_ready4); end
    tick();
    rd_valid4 = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (rd_ready4 !== seq[c]) begin n_fail++; $display("FAIL ptr4_grant %0d: got %b want %b", c, rd_ready4, seq[c]); end
      tick();
    end
    rd_valid4 = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] e_rsp;
    idle(); reset = 1'b1; tick(); reset = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset = ($urandom_range(0, 49) == 0);
      idle();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) != 0) set_wr(i, $urandom_range(0, 3), BL'($urandom), $urandom);
        if ($urandom_range(0, 3) != 0) set_rd(i, $urandom_range(0, 3));
      end
      #1;
      model_grants();
      e_rsp = exp_rsp_vld ? (N'(1) << exp_rsp_id) : '0;
      n_checks++; if (wr_ready !== exp_wr) begin n_fail++; $display("FAIL rand_wr_ready cyc %0d: got %b want %b", cyc, wr_ready, exp_wr); end
      n_checks++; if (rd_ready !== exp_rd) begin n_fail++; $display("FAIL rand_rd_ready cyc %0d: got %b want %b", cyc, rd_ready, exp_rd); end
      n_checks++; if (ram_we !== (exp_wi >= 0)) begin n_fail++; $display("FAIL rand_ram_we cyc %0d: got %b want %b", cyc, ram_we, exp_wi >= 0); end
      n_checks++; if (rsp_valid !== e_rsp) begin n_fail++; $display("FAIL rand_rsp_valid cyc %0d: got %b want %b", cyc, rsp_valid, e_rsp); end
      if (exp_rsp_vld) begin
        n_checks++; if (rsp_data !== exp_rsp_data) begin n_fail++; $display("FAIL rand_rsp_data cyc %0d: got %h want %h", cyc, rsp_data, exp_rsp_data); end
      end
      if (exp_wi >= 0) begin
        n_checks++;
        if (ram_waddr !== wr_addr[exp_wi*AW +: AW] || ram_wdata !== wr_data[exp_wi*DW +: DW] || ram_be !== wr_be[exp_wi*BL +: BL]) begin
          n_fail++;
          $display("FAIL rand_ram_wr cyc %0d: got a=%0d be=%b d=%h want a=%0d be=%b d=%h", cyc, ram_waddr, ram_be, ram_wdata,
                   wr_addr[exp_wi*AW +: AW], wr_be[exp_wi*BL +: BL], wr_data[exp_wi*DW +: DW]);
        end
      end
      if (exp_ri >= 0) begin
        n_checks++; if (ram_raddr !== rd_addr[exp_ri*AW +: AW]) begin n_fail++; $display("FAIL rand_ram_raddr cyc %0d: got %0d want %0d", cyc, ram_raddr, rd_addr[exp_ri*AW +: AW]); end
      end
      tick();
    end
    reset = 1'b0; idle();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    wptr = 0; rptr = 0; exp_rsp_vld = 1'b0; exp_rsp_id = 0; exp_rsp_data = '0;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    rd_valid4 = '0; rd_addr4 = '0;
    idle(); reset = 1'b1; mem_clr = 1'b1;
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_fairness();
    test_hazard();
    test_zero_be();
    test_ptr4();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_ram_rr_scheduler.md
# byte_ram_rr_scheduler

Shares one byte-enabled simple dual-port RAM (one write port, one registered read port) between N requesters. Write and read ports are arbitrated independently, each round-robin, so one write and one read can retire per cycle. Read responses are returned one cycle after grant, with bytes written in the same cycle forwarded into the response. Sits between bus-side agents (AXI4 slave front ends, DMA engines) and the RAM macro.

## Interface
- N, 2, number of requesters (2..8)
- AW, 6, RAM address width
- DW, 32, RAM data width; byte lanes BL = DW/8
- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- wr_valid  in  N  per-requester write request
- wr_ready  out  N  write grant, one-hot or zero
- wr_addr  in  N*AW  write address, requester i at [i*AW +: AW]
- wr_be  in  N*BL  byte enables, requester i at [i*BL +: BL]
- wr_data  in  N*DW  write data, requester i at [i*DW +: DW]
- rd_valid  in  N  per-requester read request
- rd_ready  out  N  read grant, one-hot or zero
- rd_addr  in  N*AW  read address, requester i at [i*AW +: AW]
- rsp_valid  out  N  one-hot read response strobe
- rsp_data  out  DW  read data, shared across requesters
- ram_we  out  1  RAM write enable
- ram_waddr  out  AW  RAM write address
- ram_be  out  BL  RAM byte enables
- ram_wdata  out  DW  RAM write data
- ram_raddr  out  AW  RAM read address
- ram_q  in  DW  RAM registered read data (valid one cycle after ram_raddr)

## Operation
- Requester holds valid and payload stable until ready; transfer = valid & ready in the same cycle. ready may depend combinationally on valid; valid must not depend on ready.
- Write arbiter: wr_ptr (log2 N bits). Grant first i with wr_valid[i], searching wr_ptr, wr_ptr+1, ... modulo N. On grant, wr_ptr <= granted+1 mod N; with no grant wr_ptr holds.
- Read arbiter: identical, separate rd_ptr.
- ram_we = |wr_ready; ram_waddr/ram_be/ram_wdata = granted requester's payload, else zeros. ram_raddr = granted read address, else zero.
- Write with wr_be = 0 is still granted and consumes a slot; RAM contents unchanged.
- Response: rsp_id register captures read grant; rsp_valid = one-hot of rsp_id one cycle after read transfer, all-zero otherwise. No backpressure on responses; requester must accept.
- Same-cycle read/write hazard: RAM returns pre-write data when read and write addresses match in one cycle. Scheduler registers hit = ram_we & rd granted & (ram_waddr == ram_raddr), plus ram_be and ram_wdata. Next cycle, per byte lane b: rsp_data lane b = (hit & be_r[b]) ? wdata_r lane b : ram_q lane b.
- Write in cycle t followed by read of same address in t+1 needs no forwarding (RAM already updated).
- A requester may have read and write granted in the same cycle.
- rsp_data is don't-care when rsp_valid is zero (implemented as merged ram_q).

## Timing
- Reset (synchronous, sampled at clk edge): wr_ptr = 0, rd_ptr = 0, rsp_valid = 0, hit = 0, be_r = 0, wdata_r = 0. While reset is high, wr_ready = 0, rd_ready = 0, ram_we = 0, ram_raddr = 0 regardless of valids.
- Reset asserted the cycle after a read grant: the response is dropped (rsp_valid = 0 after reset edge).
- Grant latency: 0 cycles (combinational arbitration). Write visible to a read granted in the next cycle.
- Read latency: grant at cycle t, rsp_valid/rsp_data at cycle t+1. Back-to-back reads sustain one response per cycle.
- Fairness: with all N requesters continuously valid, each is granted exactly once every N cycles per port.
- Pointer wrap: granted index N-1 sets pointer to 0.

## Test plan
- Reset, then requester 0 writes addr 5, be 4'b1111, data 32'hDEADBEEF; next cycle requester 1 reads addr 5 -> rsp_valid = 2'b10 one cycle later, rsp_data = 32'hDEADBEEF.
- N=2, both wr_valid held high 6 cycles -> wr_ready sequence 01,10,01,10,01,10; same for rd_valid independently.
- Addr 9 holds 32'h11223344; same cycle requester 0 writes addr 9 be 4'b0101 data 32'hAABBCCDD and requester 1 reads addr 9 -> rsp_data = 32'h11BB33DD; read of addr 9 next cycle -> 32'h11BB33DD from RAM.
- Write be 4'b0000 to addr 3 holding 32'h12345678 -> wr_ready asserted, readback 32'h12345678.
- Reset asserted with all valids high -> all ready, ram_we, rsp_valid zero; after release first grants go to requester 0.
- N=4, requesters 1 and 3 valid, rd_ptr = 2 -> grant 3, then 1, then 3.
